data_memory: RTL and testbench

Data-memory responder for the pipelined RV32 core: the memory end of the controller's load/store interface. Serves combinational reads with byte-lane alignment and accepts registered writes (sb/sh/sw) through a one-entry store buffer, with read-after-write forwarding. Flags misaligned stores. Optionally zero-fills the array after reset.

---
 rtl/data_memory_pkg.sv | 15 +
 rtl/dmem_store_buffer.sv | 83 ++++++++
 rtl/data_memory.sv | 106 ++++++++++
 tb/tb_data_memory.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - Shared widths, func3 size codes and clear-FSM states for the data memory.
package data_memory_pkg;
    localparam int DataWidth  = 32;
    localparam int AddrWidth  = 32;
    localparam int Func3Width = 3;

    localparam logic [Func3Width-1:0] MemByte = 3'd0;
    localparam logic [Func3Width-1:0] MemHalf = 3'd1;
    localparam logic [Func3Width-1:0] MemWord = 3'd2;

    typedef enum logic {
        DMemClear = 1'b0,
        DMemReady = 1'b1
    } dmem_state_t;
endpackage

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - One-entry store buffer: lane mask/data build, misalign check, read forwarding merge.
import data_memory_pkg::*;

module dmem_store_buffer #(
    parameter int DEPTH = 1024,
    localparam int IdxWidth = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_en,
    input  logic [AddrWidth-1:0]  write_addr,
    input  logic [DataWidth-1:0]  write_data,
    input  logic [Func3Width-1:0] write_func3,
    input  logic [IdxWidth-1:0]   read_index,
    input  logic [DataWidth-1:0]  array_word,
    output logic                  commit_valid,
    output logic [IdxWidth-1:0]   commit_index,
    output logic [3:0]            commit_mask,
    output logic [DataWidth-1:0]  commit_data,
    output logic [DataWidth-1:0]  merged_word,
    output logic                  misaligned
);
    logic [1:0]           lane_off;
    logic [IdxWidth-1:0]  write_index;
    logic [3:0]           lane_mask;
    logic [DataWidth-1:0] lane_data;
    logic                 size_ok;
    logic                 aligned;
    logic                 capture;
    logic                 misaligned_next;
    logic                 unused_addr_bits;

    assign lane_off         = write_addr[1:0];
    assign write_index      = write_addr[IdxWidth+1:2];
    assign unused_addr_bits = ^write_addr[AddrWidth-1:IdxWidth+2];
    assign lane_data        = write_data << {lane_off, 3'b000};

    always_comb begin
        size_ok   = 1'b1;
        aligned   = 1'b1;
        lane_mask = 4'b0000;
        case (write_func3)
            MemByte: lane_mask = 4'b0001 << lane_off;
            MemHalf: begin
                lane_mask = 4'b0011 << lane_off;
                aligned   = ~lane_off[0];
            end
            MemWord: begin
                lane_mask = 4'b1111;
                aligned   = (lane_off == 2'd0);
            end
            default: size_ok = 1'b0;
        endcase
    end

    // Unknown size codes are dropped silently; only real sizes can be misaligned.
    assign capture         = capture_en & size_ok & aligned;
    assign misaligned_next = capture_en & size_ok & ~aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            commit_valid <= capture;
            misaligned   <= misaligned_next;
            if (capture) begin
                commit_index <= write_index;
                commit_mask  <= lane_mask;
                commit_data  <= lane_data;
            end
        end
    end

    always_comb begin
        merged_word = array_word;
        if (commit_valid && (commit_index == read_index)) begin
            for (int i = 0; i < 4; i++) begin
                if (commit_mask[i]) merged_word[8*i +: 8] = commit_data[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - RV32 data memory: word array, clear FSM, byte-aligned reads (DMEM_CLEAR_EN zero-fills after reset).
import data_memory_pkg::*;

module data_memory #(
    parameter int DEPTH = 1024,
    localparam int IdxWidth = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AddrWidth-1:0]  memReadAddr,
    output logic [DataWidth-1:0]  memReadData,
    input  logic                  memWriteEnable,
    input  logic [AddrWidth-1:0]  memWriteAddr,
    input  logic [DataWidth-1:0]  memWriteData,
    input  logic [Func3Width-1:0] memWriteFunc3,
    output logic                  memReady,
    output logic                  memMisaligned
);
    logic [DataWidth-1:0] mem [DEPTH];
    dmem_state_t          state, state_next;
    logic [IdxWidth-1:0]  read_index;
    logic [DataWidth-1:0] array_word;
    logic [DataWidth-1:0] merged_word;
    logic                 commit_valid;
    logic [IdxWidth-1:0]  commit_index;
    logic [3:0]           commit_mask;
    logic [DataWidth-1:0] commit_data;
    logic                 unused_read_bits;
`ifdef DMEM_CLEAR_EN
    logic [IdxWidth-1:0]  clear_index, clear_index_next;
    logic                 clear_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DMemClear;
`ifdef DMEM_CLEAR_EN
            clear_index <= '0;
`endif
        end else begin
            state <= state_next;
`ifdef DMEM_CLEAR_EN
            clear_index <= clear_index_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
`ifdef DMEM_CLEAR_EN
        clear_index_next = clear_index;
        clear_we         = 1'b0;
`endif
        case (state)
            DMemClear: begin
`ifdef DMEM_CLEAR_EN
                clear_we         = 1'b1;
                clear_index_next = clear_index + IdxWidth'(1);
                if (clear_index == IdxWidth'(DEPTH - 1)) state_next = DMemReady;
`else
                state_next = DMemReady;
`endif
            end
            DMemReady: state_next = DMemReady;
            default:   state_next = DMemClear;
        endcase
    end

    assign memReady = (state == DMemReady);

    // A reset edge must not commit the pending entry or advance the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef DMEM_CLEAR_EN
            if (clear_we) mem[clear_index] <= '0;
`endif
            if (commit_valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (commit_mask[i]) mem[commit_index][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    dmem_store_buffer #(.DEPTH(DEPTH)) u_store_buffer (
        .clk          (clk),
        .rst          (rst),
        .capture_en   (memWriteEnable & memReady),
        .write_addr   (memWriteAddr),
        .write_data   (memWriteData),
        .write_func3  (memWriteFunc3),
        .read_index   (read_index),
        .array_word   (array_word),
        .commit_valid (commit_valid),
        .commit_index (commit_index),
        .commit_mask  (commit_mask),
        .commit_data  (commit_data),
        .merged_word  (merged_word),
        .misaligned   (memMisaligned)
    );

    assign read_index       = memReadAddr[IdxWidth+1:2];
    assign unused_read_bits = ^memReadAddr[AddrWidth-1:IdxWidth+2];
    assign array_word       = mem[read_index];
    assign memReadData      = memReady ? (merged_word >> {memReadAddr[1:0], 3'b000}) : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - Directed plus randomized bench for data_memory against a byte-level memory model.
module tb_data_memory;
    localparam int DEPTH = 64;
`ifdef DMEM_CLEAR_EN
    localparam int ReadyCycles = DEPTH;
`else
    localparam int ReadyCycles = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] memReadAddr;
    logic [31:0] memReadData;
    logic        memWriteEnable;
    logic [31:0] memWriteAddr;
    logic [31:0] memWriteData;
    logic [2:0]  memWriteFunc3;
    logic        memReady;
    logic        memMisaligned;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .memReadAddr    (memReadAddr),
        .memReadData    (memReadData),
        .memWriteEnable (memWriteEnable),
        .memWriteAddr   (memWriteAddr),
        .memWriteData   (memWriteData),
        .memWriteFunc3  (memWriteFunc3),
        .memReady       (memReady),
        .memMisaligned  (memMisaligned)
    );

    always #5 clk = ~clk;

    logic [31:0] model_mem [DEPTH];
    bit          model_ready;
    bit          pend_valid;
    int          pend_idx;
    logic [31:0] pend_old;
    int          vectors;
    int          miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] w;
        w = model_mem[(addr / 4) % DEPTH];
        return w >> (8 * (addr % 4));
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] f3, output bit mis, output bit took);
        int size;
        int off;
        int idx;
        off  = addr % 4;
        idx  = (addr / 4) % DEPTH;
        mis  = 0;
        took = 0;
        case (f3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) return;
        if (off % size != 0) begin
            mis = 1;
            return;
        end
        pend_old = model_mem[idx];
        pend_idx = idx;
        took     = 1;
        for (int b = 0; b < size; b++) model_mem[idx][8*(off+b) +: 8] = data[8*b +: 8];
    endtask

    task automatic tick();
        bit mis;
        bit took;
        mis  = 0;
        took = 0;
        @(posedge clk);
        if (rst) begin
            if (pend_valid) model_mem[pend_idx] = pend_old;
            pend_valid  = 0;
            model_ready = 0;
        end else begin
            if (model_ready && memWriteEnable)
                model_store(memWriteAddr, memWriteData, memWriteFunc3, mis, took);
            pend_valid = took;
        end
        #1;
        check("misaligned", {31'b0, memMisaligned}, {31'b0, mis});
    endtask

    task automatic check_read(input logic [31:0] addr);
        memReadAddr = addr;
        #1;
        check($sformatf("read@%h", addr), memReadData, model_read(addr));
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        memWriteEnable = 1'b1;
        memWriteAddr   = addr;
        memWriteData   = data;
        memWriteFunc3  = f3;
        tick();
        memWriteEnable = 1'b0;
    endtask

    task automatic wait_ready(input int expected);
        int n;
        n = 0;
        while (memReady !== 1'b1 && n < DEPTH + 20) begin
            tick();
            n++;
        end
        check("ready_latency", n, expected);
        check("ready", {31'b0, memReady}, 32'd1);
        model_ready = 1;
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
    endtask

    initial begin
        logic [31:0] waddr;
        vectors        = 0;
        miscompares    = 0;
        model_ready    = 0;
        pend_valid     = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        rst            = 1'b1;
        memReadAddr    = 32'h10;
        memWriteEnable = 1'b0;
        memWriteAddr   = '0;
        memWriteData   = '0;
        memWriteFunc3  = 3'd2;

        repeat (2) tick();
        check("ready_in_reset", {31'b0, memReady}, 32'd0);
        check("read_in_reset", memReadData, 32'd0);
        store(32'h10, 32'h55555555, 3'd2);
        rst = 1'b0;
        wait_ready(ReadyCycles);

        // Known contents everywhere, written back-to-back.
        for (int i = 0; i < DEPTH; i++) store(32'(4 * i), 32'h0, 3'd2);

        store(32'h10, 32'hDEADBEEF, 3'd2);
        check_read(32'h10);
        check("fwd_word", memReadData, 32'hDEADBEEF);
        repeat (2) tick();
        check_read(32'h10);
        check("array_word", memReadData, 32'hDEADBEEF);

        store(32'h12, 32'h000000AA, 3'd0);
        check_read(32'h10);
        check("sb_word", memReadData, 32'hDEAABEEF);
        check_read(32'h12);
        check("sb_half", memReadData, 32'h0000DEAA);
        check_read(32'h13);
        check("sb_byte", memReadData, 32'h000000DE);

        store(32'h21, 32'h1234, 3'd1);
        tick();
        store(32'h22, 32'hFFFFFFFF, 3'd2);
        tick();
        check_read(32'h20);

        memWriteEnable = 1'b1;
        memWriteAddr   = 32'h30;
        memWriteData   = 32'h11111111;
        memWriteFunc3  = 3'd2;
        check_read(32'h30);
        check("same_cycle", memReadData, 32'h0);
        tick();
        memWriteEnable = 1'b0;
        check_read(32'h30);
        check("after_edge", memReadData, 32'h11111111);

        store(32'h40, 32'd1, 3'd2);
        store(32'h44, 32'd2, 3'd2);
        store(32'h40, 32'd3, 3'd2);
        check_read(32'h40);
        check_read(32'h44);
        tick();
        check_read(32'h40 + 4 * DEPTH);
        check("alias", memReadData, 32'd3);

        store(32'h50, 32'hFFFF, 3'd3);
        check_read(32'h50);

        // Store pending at the reset edge must be discarded.
        store(32'h60, 32'd5, 3'd2);
        tick();
        store(32'h60, 32'hCAFEF00D, 3'd2);
        rst = 1'b1;
        tick();
        check("read_during_reset", memReadData, 32'h0);
        rst = 1'b0;
        wait_ready(ReadyCycles);
        check_read(32'h60);

`ifdef DMEM_CLEAR_EN
        store(32'h14, 32'hFFFFFFFF, 3'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        memWriteEnable = 1'b1;
        memWriteAddr   = 32'h18;
        memWriteData   = 32'hA5A5A5A5;
        memWriteFunc3  = 3'd2;
        wait_ready(DEPTH);
        memWriteEnable = 1'b0;
        check_read(32'h14);
        check_read(32'h18);
`endif

        waddr = 32'h0;
        for (int it = 0; it < 400; it++) begin
            memWriteEnable = 1'($urandom_range(0, 1));
            waddr          = $urandom_range(0, 8 * DEPTH - 1);
            memWriteAddr   = waddr;
            memWriteData   = $urandom;
            memWriteFunc3  = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                check_read({waddr[31:2], 2'($urandom_range(0, 3))});
            else
                check_read($urandom_range(0, 8 * DEPTH - 1));
            tick();
            check_read({waddr[31:2], 2'($urandom_range(0, 3))});
        end
        memWriteEnable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
